// File: rtl/stream_to_bus_deser.sv
// Reassembles address-then-data byte frames (LSB first) into one bus write; bso_vld one cycle after the last byte.
// One write can wait for bso_rdy while the next frame is assembled; after that sti_rdy drops until the output drains.
module stream_to_bus_deser #(
  parameter int ADR_BYTES = 4,
  parameter int DAT_BYTES = 4,
  parameter int CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sti_vld,
  input  logic [7:0]             sti_bus,
  output logic                   sti_rdy,
  output logic                   bso_vld,
  output logic [8*ADR_BYTES-1:0] bso_adr,
  output logic [8*DAT_BYTES-1:0] bso_dat,
  input  logic                   bso_rdy,
  output logic [CNT_W-1:0]       frm_cnt,
  output logic                   busy
);

  localparam int AW    = 8 * ADR_BYTES;
  localparam int DW    = 8 * DAT_BYTES;
  localparam int N     = ADR_BYTES + DAT_BYTES;
  localparam int IDX_W = (N > 2) ? $clog2(N) : 1;

  typedef enum logic {FILL = 1'b0, FULL = 1'b1} asm_st_t;

  asm_st_t          asm_st_q;
  logic [IDX_W-1:0] idx_q;
  logic [AW-1:0]    asm_adr_q;
  logic [DW-1:0]    asm_dat_q;
  logic             bso_vld_q;
  logic [AW-1:0]    bso_adr_q;
  logic [DW-1:0]    bso_dat_q;
  logic [CNT_W-1:0] frm_cnt_q;

  logic          xfer;
  logic          last_byte;
  logic          out_free;
  logic          bus_done;
  logic [AW-1:0] asm_adr_d;
  logic [DW-1:0] asm_dat_d;

  // sti_rdy depends only on registered state and rst, never on bso_rdy or sti_vld.
  assign sti_rdy   = (asm_st_q == FILL) & ~rst;
  assign xfer      = sti_vld & sti_rdy;
  assign last_byte = xfer & (idx_q == IDX_W'(N - 1));
  assign bus_done  = bso_vld_q & bso_rdy;
  assign out_free  = ~bso_vld_q | bso_rdy;

  // Current byte merged in, so a completing frame can go straight to the output registers.
  always_comb begin
    asm_adr_d = asm_adr_q;
    asm_dat_d = asm_dat_q;
    if (xfer) begin
      for (int k = 0; k < ADR_BYTES; k++) begin
        if (idx_q == IDX_W'(k)) asm_adr_d[8*k +: 8] = sti_bus;
      end
      for (int k = 0; k < DAT_BYTES; k++) begin
        if (idx_q == IDX_W'(ADR_BYTES + k)) asm_dat_d[8*k +: 8] = sti_bus;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_st_q  <= FILL;
      idx_q     <= '0;
      asm_adr_q <= '0;
      asm_dat_q <= '0;
      bso_vld_q <= 1'b0;
      bso_adr_q <= '0;
      bso_dat_q <= '0;
      frm_cnt_q <= '0;
    end else begin
      asm_adr_q <= asm_adr_d;
      asm_dat_q <= asm_dat_d;

      if (xfer) begin
        idx_q <= last_byte ? '0 : idx_q + IDX_W'(1);
      end

      if (bus_done) begin
        frm_cnt_q <= frm_cnt_q + CNT_W'(1);
      end

      case (asm_st_q)
        FILL: begin
          if (last_byte && out_free) begin
            bso_vld_q <= 1'b1;
            bso_adr_q <= asm_adr_d;
            bso_dat_q <= asm_dat_d;
          end else begin
            if (bus_done) bso_vld_q <= 1'b0;
            if (last_byte) asm_st_q <= FULL;
          end
        end
        FULL: begin
          if (out_free) begin
            bso_vld_q <= 1'b1;
            bso_adr_q <= asm_adr_q;
            bso_dat_q <= asm_dat_q;
            asm_st_q  <= FILL;
          end
        end
        default: asm_st_q <= FILL;
      endcase
    end
  end

  assign bso_vld = bso_vld_q;
  assign bso_adr = bso_adr_q;
  assign bso_dat = bso_dat_q;
  assign frm_cnt = frm_cnt_q;
  assign busy    = (idx_q != '0) | (asm_st_q == FULL) | bso_vld_q;

endmodule

// File: doc/stream_to_bus_deser.md
Name: stream_to_bus_deser

Overview:
- Receiving end of the byte-stream link that carries bus write transfers.
- Accepts an 8-bit valid/ready stream, reassembles each frame of address bytes followed by data bytes into one address/data pair, and issues it as a single valid/ready bus write.
- Sits between the stream link and the downstream bus target.
- Two-stage buffered: the next frame is assembled while the previous bus write waits for ready.

Parameters:
ADR_BYTES, 4, address bytes per frame; address width AW = 8*ADR_BYTES
DAT_BYTES, 4, data bytes per frame; data width DW = 8*DAT_BYTES
CNT_W, 16, width of the completed-frame counter

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset, asynchronous, active-high
sti_vld  input  1  stream byte valid
sti_bus  input  8  stream byte
sti_rdy  output  1  stream ready; a byte transfers when sti_vld & sti_rdy
bso_vld  output  1  bus write valid
bso_adr  output  AW  bus address
bso_dat  output  DW  bus write data
bso_rdy  input  1  bus ready; a write completes when bso_vld & bso_rdy
frm_cnt  output  CNT_W  number of completed bus writes, wraps modulo 2^CNT_W
busy  output  1  high when a partial frame is held or a write is pending

Behaviour:
- Reset values (async assert, sync release):
  - bso_vld=0, bso_adr=0, bso_dat=0, frm_cnt=0, busy=0.
  - Byte index=0, assembly-full flag=0.
  - sti_rdy=0 while rst is high.
- Frame format:
  - N = ADR_BYTES+DAT_BYTES bytes.
  - Address first, then data, each least-significant byte first.
  - Byte index k<ADR_BYTES -> asm_adr[8k+:8].
  - Byte index k>=ADR_BYTES -> asm_dat[8(k-ADR_BYTES)+:8].
- Byte index counter:
  - Counts 0..N-1 on each stream transfer.
  - Returns to 0 after byte N-1.
  - Never advances without a transfer.
- sti_rdy = ~asm_full & ~rst.
  - No combinational path from bso_rdy or sti_vld to sti_rdy.
- Assembly stage states, as a two-state view:
  - FILL: accepting bytes.
  - FULL: complete frame held, sti_rdy=0.
- Output stage states:
  - EMPTY: bso_vld=0.
  - PEND: bso_vld=1.
- Output stage is free in a cycle when it is EMPTY, or PEND with bso_rdy=1 (drains this cycle).
- Last byte (index N-1) transfers at cycle T:
  - Output free at T: the assembled frame loads the output registers. bso_vld=1 from T+1; assembly stays FILL. Latency is one cycle from the last byte to bso_vld.
  - Output not free at T: assembly goes FULL at T+1.
- Assembly FULL and output free in the same cycle:
  - Frame moves to the output; bso_vld stays or becomes 1 next cycle.
  - Assembly returns to FILL; sti_rdy=1 next cycle.
- While bso_vld=1 and bso_rdy=0: bso_adr and bso_dat are held stable.
- Write completes (bso_vld & bso_rdy) with no new frame loading: bso_vld=0 next cycle. bso_adr/bso_dat keep their last value.
- frm_cnt increments by 1 on each completed write. 2^CNT_W-1 wraps to 0.
- Throughput:
  - Back-to-back frames with bso_rdy tied high sustain one byte per cycle with no stalls.
  - With bso_rdy low, at most one frame is pending plus one frame assembled. The stream then stalls.
- busy = (index!=0) | asm_full | bso_vld.
- Reset mid-frame or mid-write:
  - Partial frame and pending write are discarded; no write is issued for them.
  - After release, the first byte received is byte 0 of a new frame.
- The stream has no framing marker. Alignment relies only on the byte index, so the upstream serializer must send whole frames.

Test Plan:
- Single frame, bso_rdy=1: bytes 78 56 34 12 EF BE AD DE on consecutive cycles -> one cycle after the last byte, bso_vld=1 with bso_adr=32'h12345678 and bso_dat=32'hDEADBEEF for exactly 1 cycle; frm_cnt=1.
- Backpressure: bso_rdy=0, stream three frames continuously -> frame 1 pending, frame 2 assembled, sti_rdy=0 from the cycle after frame 2's last byte, bso_adr/dat stable. Raise bso_rdy -> frames 1 and 2 delivered on consecutive completes, sti_rdy=1 again; frame 3 then delivered; no loss or duplication.
- Stream gaps: sti_vld toggled randomly -> index advances only on transfers; ten random frames arrive in order with correct values, frm_cnt=10.
- Reset mid-frame: after 3 bytes of a frame, pulse rst asynchronously -> bso_vld=0, sti_rdy=0 during reset. Afterwards, a full 8-byte frame decodes correctly; the partial bytes do not appear.
- Reset with a pending write: bso_vld=1, bso_rdy=0, assert rst -> bso_vld=0 immediately (async); frm_cnt=0; no write completes.
- End-to-end loopback with the bus-to-stream serializer: ten $random writes to addresses 0..9 -> captured memory equals source memory; frm_cnt=10.
